// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern transmitter: FSM states and parameter bounds.
package pattern_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;
    localparam int unsigned LAG_MIN   = 1;
    localparam int unsigned LAG_MAX   = 8;
    localparam int unsigned REPS_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_tx_if.sv
// Load channel of the pattern transmitter: valid/ready handshake with word and repeat count.
interface pattern_tx_if #(parameter int unsigned WIDTH = 16) ();
    import pattern_pkg::*;

    logic              load_valid;
    logic              load_ready;
    logic [WIDTH-1:0]  load_data;
    logic [REPS_W-1:0] load_reps;

    modport master (output load_valid, output load_data, output load_reps, input  load_ready);
    modport slave  (input  load_valid, input  load_data, input  load_reps, output load_ready);

endinterface

// File: rtl/lag_history.sv
// Shift register of the last LAG stream bits plus a saturating fill count.
// Exposes the post-update tap and fill so the caller can register outputs for the next bit.
module lag_history #(
    parameter int unsigned LAG = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic shift,
    input  logic din,
    output logic tap_nxt_c,
    output logic full_nxt_c
);
    localparam int unsigned FILL_W = $clog2(LAG + 1);

    logic [LAG-1:0]    hist, hist_nxt;
    logic [FILL_W-1:0] fill, fill_nxt;

    always_comb begin
        hist_nxt = hist;
        fill_nxt = fill;
        if (clr) begin
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (shift) begin
            hist_nxt = LAG'({hist, din});
            if (fill != FILL_W'(LAG)) fill_nxt = fill + FILL_W'(1);
        end
    end

    assign tap_nxt_c  = hist_nxt[LAG-1];
    assign full_nxt_c = (fill_nxt == FILL_W'(LAG));

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            fill <= '0;
        end else begin
            hist <= hist_nxt;
            fill <= fill_nxt;
        end
    end

endmodule

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a loaded word LSB first (load_reps+1) times and
// predicts, for each bit, whether it equals the bit sent LAG cycles earlier.
module pattern_tx
    import pattern_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LAG   = 2
) (
    input  logic         clk,
    input  logic         rst,
    pattern_tx_if.slave  ld,
    output logic         outval,
    output logic         out_en,
    output logic         expect_eq,
    output logic         expect_vld,
    output logic         done
);
    localparam int unsigned IDX_W = $clog2(WIDTH);

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [REPS_W-1:0] reps_left;
    logic [WIDTH-1:0]  word;

    logic             accept_c, last_c, nb_c, tap_nxt_c, full_nxt_c;
    logic [IDX_W-1:0] idx_inc_c;

    assign accept_c  = ld.load_valid && ld.load_ready;
    assign last_c    = (idx == IDX_W'(WIDTH - 1));
    assign idx_inc_c = idx + IDX_W'(1);
    assign nb_c      = last_c ? word[0] : word[idx_inc_c];

    // History sees the bit currently on outval; its cleared state starts each burst.
    lag_history #(.LAG(LAG)) u_hist (
        .clk        (clk),
        .rst        (rst),
        .clr        (accept_c),
        .shift      (out_en),
        .din        (outval),
        .tap_nxt_c  (tap_nxt_c),
        .full_nxt_c (full_nxt_c)
    );

    // Outputs are registered for the cycle that follows each edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            idx           <= '0;
            reps_left     <= '0;
            word          <= '0;
            outval        <= 1'b0;
            out_en        <= 1'b0;
            expect_eq     <= 1'b0;
            expect_vld    <= 1'b0;
            done          <= 1'b0;
            ld.load_ready <= 1'b1;
        end else begin
            done       <= 1'b0;
            expect_eq  <= 1'b0;
            expect_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        state         <= SEND;
                        word          <= ld.load_data;
                        reps_left     <= ld.load_reps;
                        idx           <= '0;
                        outval        <= ld.load_data[0];
                        out_en        <= 1'b1;
                        ld.load_ready <= 1'b0;
                    end
                end
                SEND: begin
                    if (last_c && reps_left == '0) begin
                        state  <= DONE;
                        idx    <= '0;
                        outval <= 1'b0;
                        out_en <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        idx        <= last_c ? '0 : idx_inc_c;
                        if (last_c) reps_left <= reps_left - REPS_W'(1);
                        outval     <= nb_c;
                        expect_vld <= full_nxt_c;
                        expect_eq  <= full_nxt_c & ~(nb_c ^ tap_nxt_c);
                    end
                end
                DONE: begin
                    state         <= IDLE;
                    ld.load_ready <= 1'b1;
                end
                default: begin
                    state         <= IDLE;
                    outval        <= 1'b0;
                    out_en        <= 1'b0;
                    ld.load_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Scoreboard bench for pattern_tx (WIDTH=16, LAG=2): directed bursts, busy loads,
// back-to-back loads, mid-burst reset and a lag-2 checker loopback over random words.
module tb_pattern_tx;

    typedef struct {
        logic b;
        logic vld;
        logic eq;
        logic first;
        logic last;
        logic chk_gap;
        int   len;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic outval, out_en, expect_eq, expect_vld, done;

    pattern_tx_if #(.WIDTH(16)) ld ();

    pattern_tx #(.WIDTH(16), .LAG(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld),
        .outval     (outval),
        .out_en     (out_en),
        .expect_eq  (expect_eq),
        .expect_vld (expect_vld),
        .done       (done)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    bit   abort = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream of one burst, derived from the loaded word.
    task automatic push_burst(input logic [15:0] d, input int reps, input bit gap);
        int n;
        exp_t e;
        n = 16 * (reps + 1);
        for (int k = 0; k < n; k++) begin
            e.b       = d[k % 16];
            e.vld     = (k >= 2);
            e.eq      = (k >= 2) ? (d[k % 16] == d[(k - 2) % 16]) : 1'b0;
            e.first   = (k == 0);
            e.last    = (k == n - 1);
            e.chk_gap = gap && (k == 0);
            e.len     = n;
            q.push_back(e);
        end
    endtask

    // Monitor: pops one expectation per out_en cycle; also models a downstream lag-2 checker.
    int   cyc = 0, last_cyc = 0, burst_len = 0, exp_len = 0;
    bit   in_burst = 1'b0, pending_done = 1'b0;
    logic h1 = 1'b0, h2 = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        logic chk;
        if (abort) begin
            in_burst     = 1'b0;
            pending_done = 1'b0;
            abort        = 1'b0;
        end
        if (out_en === 1'b1) begin
            if (q.size() == 0) begin
                check("unexpected_bit", 32'(out_en), 32'd0);
            end else begin
                e = q.pop_front();
                if (e.first) begin
                    burst_len = 0;
                    if (e.chk_gap) check("b2b_spacing", 32'(cyc - last_cyc), 32'd3);
                end
                burst_len++;
                check("outval", 32'(outval), 32'(e.b));
                check("expect_vld", 32'(expect_vld), 32'(e.vld));
                check("expect_eq", 32'(expect_eq), 32'(e.eq));
                check("done_in_send", 32'(done), 32'd0);
                if (e.last) begin
                    pending_done = 1'b1;
                    last_cyc     = cyc;
                    exp_len      = e.len;
                end
                in_burst = !e.last;
            end
            chk = ~(outval ^ h2);
            if (expect_vld === 1'b1) check("loopback", 32'(expect_eq), 32'(chk));
            h2 = h1;
            h1 = outval;
        end else begin
            if (in_burst) check("burst_gap", 32'(out_en), 32'd1);
            in_burst = 1'b0;
            if (pending_done) begin
                check("done_pulse", 32'(done), 32'd1);
                check("done_outval", 32'(outval), 32'd0);
                check("burst_len", 32'(burst_len), 32'(exp_len));
                pending_done = 1'b0;
            end else begin
                check("no_done", 32'(done), 32'd0);
            end
        end
        cyc++;
    end

    task automatic wait_ready();
        int n = 0;
        while (ld.load_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (ld.load_ready !== 1'b1) check("ready_timeout", 32'(ld.load_ready), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input int reps);
        wait_ready();
        ld.load_valid = 1'b1;
        ld.load_data  = d;
        ld.load_reps  = 4'(reps);
        push_burst(d, reps, 1'b0);
        @(posedge clk); #1;
        ld.load_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        bit exp_b [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        bit exp_v [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        bit exp_e [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
        int n;

        // Reset, with a load presented that must be ignored.
        rst = 1'b1;
        ld.load_valid = 1'b1;
        ld.load_data  = 16'hFFFF;
        ld.load_reps  = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_en", 32'(out_en), 32'd0);
        check("rst_outval", 32'(outval), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_expect", 32'({expect_vld, expect_eq}), 32'd0);
        ld.load_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(ld.load_ready), 32'd1);
        check("no_load_in_rst", 32'(out_en), 32'd0);

        // A5A5, reps 0, with hand-computed first bits.
        do_load(16'hA5A5, 0);
        for (int k = 0; k <= 16; k++) begin
            if (k < 8) begin
                check("a5_bit", 32'(outval), 32'(exp_b[k]));
                check("a5_vld", 32'(expect_vld), 32'(exp_v[k]));
                check("a5_eq", 32'(expect_eq), 32'(exp_e[k]));
            end
            if (k == 16) check("a5_done", 32'(done), 32'd1);
            @(posedge clk); #1;
        end
        drain();

        // 0001, reps 2: 48 contiguous bits, ones at 0/16/32.
        do_load(16'h0001, 2);
        for (int k = 0; k <= 48; k++) begin
            if (k < 48) begin
                check("r2_en", 32'(out_en), 32'd1);
                check("r2_bit", 32'(outval), 32'((k % 16) == 0));
            end else begin
                check("r2_done", 32'(done), 32'd1);
            end
            @(posedge clk); #1;
        end
        drain();

        // Load attempted while busy must be ignored.
        do_load(16'h1234, 0);
        ld.load_valid = 1'b1;
        ld.load_data  = 16'hFFFF;
        ld.load_reps  = 4'd5;
        for (int k = 0; k < 10; k++) begin
            check("busy_ready", 32'(ld.load_ready), 32'd0);
            @(posedge clk); #1;
        end
        ld.load_valid = 1'b0;
        drain();

        // Back-to-back loads with load_valid held high.
        wait_ready();
        ld.load_valid = 1'b1;
        ld.load_data  = 16'h00FF;
        ld.load_reps  = 4'd0;
        push_burst(16'h00FF, 0, 1'b0);
        @(posedge clk); #1;
        ld.load_data = 16'h0F0F;
        push_burst(16'h0F0F, 0, 1'b1);
        n = 0;
        while (ld.load_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_ready", 32'(ld.load_ready), 32'd1);
        @(posedge clk); #1;
        ld.load_valid = 1'b0;
        drain();

        // Reset asserted during burst bit 5.
        do_load(16'hBEEF, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out", 32'({outval, out_en, expect_eq, expect_vld, done}), 32'd0);
        abort = 1'b1;
        q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", 32'(ld.load_ready), 32'd1);
        do_load(16'h3C3C, 0);
        check("fresh_bit0", 32'(outval), 32'd0);
        drain();

        // Loopback across random words.
        for (int i = 0; i < 100; i++) do_load(16'($urandom), 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
